seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Sequential radix-2 shift-add multiplier producing the full 2*SIZE-bit product of two SIZE-bit operands.
//  Sits directly upstream of the divider in the ElGamal modular-multiply path.
//  Its output stream drives the divider's 2*SIZE-bit dividend input; the modulus goes to the divisor input.
//  AXI-stream style handshakes on both operand inputs and on the product output.
// PARAMETERS
//  SIZE  64  operand width in bits (>=2); product width is 2*SIZE
// PORTS
//  clk                   in   1        system clock, single clock domain
//  rst                   in   1        reset: one clock; reset is asynchronous and active-low
//  input_a_tdata         in   SIZE     multiplicand
//  input_a_tvalid        in   1        multiplicand valid
//  input_a_tready        out  1        multiplicand accepted this cycle
//  input_b_tdata         in   SIZE     multiplier
//  input_b_tvalid        in   1        multiplier valid
//  input_b_tready        out  1        multiplier accepted this cycle
//  output_tdata          out  2*SIZE   product a*b, registered
//  output_tvalid         out  1        product valid
//  output_tready         in   1        downstream (divider) accepts product
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, output_tvalid=0, output_tdata=0, internal acc/count=0.
//   While rst is low, both treadys=0. Reset mid-operation aborts: no product is ever emitted for that pair.
//  FSM states: IDLE -> MUL -> DONE -> IDLE.
//  IDLE:
//   - input_a_tready = input_b_tready = input_a_tvalid & input_b_tvalid (joint handshake).
//   - Both operands are consumed on the same edge, or neither is. A lone valid is never accepted.
//   - On accept: a_reg<=zero-extended a (2*SIZE bits), b_reg<=b, acc<=0, count<=0, -> MUL.
//  MUL:
//   - Each cycle: if b_reg[0], acc<=acc+a_reg; then a_reg<=a_reg<<1, b_reg<=b_reg>>1, count<=count+1.
//   - Exactly SIZE iterations. No early exit; latency is data-independent.
//   - On the SIZE-th iteration: output_tdata<=final acc, output_tvalid<=1, -> DONE.
//   - Both treadys are 0 in MUL.
//  DONE:
//   - output_tdata and output_tvalid are held stable until output_tready is high.
//   - Handshake edge (tvalid & tready): output_tvalid<=0, -> IDLE. output_tdata keeps its last value.
//   - Both treadys are 0 in DONE; no overlap of a new operation with a pending result.
//  Latency: output_tvalid rises exactly SIZE clock edges after the accept edge.
//   Minimum spacing between accepts is SIZE+2 cycles.
//  Widths:
//   - acc, a_reg are 2*SIZE bits; count is $clog2(SIZE+1) bits.
//   - Max product (2^SIZE-1)^2 fits 2*SIZE bits; no overflow or carry-out is possible.
//  Boundaries:
//   - Zero operand(s) still take the full SIZE cycles and produce 0.
//   - output_tready high before tvalid has no effect.
//   - Input valids toggling during MUL/DONE are ignored and not consumed.
//   - Operand tdata may change after acceptance without affecting the result.
// TESTING (bench at SIZE=8 unless stated; tready=1 unless stated)
//  1. a=3, b=5 -> tvalid high 8 edges after accept, tdata=15; back to IDLE the cycle after handshake.
//  2. a=255, b=255 -> tdata=0xFE01. Then a=0, b=200 -> tdata=0 after the same 8-cycle latency.
//  3. a_tvalid=1, b_tvalid=0 for 10 cycles -> both treadys stay 0, no accept.
//     Raise b_tvalid with b=7, a=9 -> accept on that edge, tdata=63.
//  4. Backpressure: output_tready=0 for 20 cycles after tvalid -> tdata=63 and tvalid=1 held stable.
//     Treadys stay 0 despite new valid inputs. Raise tready -> single handshake, then next pair accepted.
//  5. Reset mid-op: assert rst low at iteration 4 of a=100, b=100 -> tvalid=0 immediately.
//     After release, a=12, b=11 -> tdata=132; 10000 never appears.
//  6. SIZE=64: a=b=2^64-1 -> tdata=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, latency 64.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Radix-2 shift-add multiplier. It produces the full 2*SIZE-bit product of two
//   SIZE-bit operands in exactly SIZE cycles, whatever the operand values.
//   Its result stream feeds the divider's dividend input in the ElGamal
//   modular-multiply path.
//
// Ports
//   clk              system clock
//   rst              asynchronous, active-low reset
//   input_a_tdata    multiplicand            (SIZE bits)
//   input_a_tvalid   multiplicand valid
//   input_a_tready   multiplicand accepted this cycle
//   input_b_tdata    multiplier              (SIZE bits)
//   input_b_tvalid   multiplier valid
//   input_b_tready   multiplier accepted this cycle
//   output_tdata     registered product a*b  (2*SIZE bits)
//   output_tvalid    product valid
//   output_tready    downstream accepts the product
module seq_multiplier #(
  parameter int SIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     input_a_tdata,
  input  logic                input_a_tvalid,
  output logic                input_a_tready,
  input  logic [SIZE-1:0]     input_b_tdata,
  input  logic                input_b_tvalid,
  output logic                input_b_tready,
  output logic [2*SIZE-1:0]   output_tdata,
  output logic                output_tvalid,
  input  logic                output_tready
);

  localparam int CNT_W = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [2*SIZE-1:0]   a_reg;
  logic [2*SIZE-1:0]   acc;
  logic [2*SIZE-1:0]   acc_next;
  logic [SIZE-1:0]     b_reg;
  logic [CNT_W-1:0]    count;
  logic                accept;

  // Conditionally add the shifted multiplicand. The full product always fits
  // in 2*SIZE bits, so the sum cannot carry out.
  function automatic logic [2*SIZE-1:0] add_partial(
    input logic [2*SIZE-1:0] sum,
    input logic [2*SIZE-1:0] addend,
    input logic              sel
  );
    return sel ? (sum + addend) : sum;
  endfunction

  // Joint handshake. Both operands are taken on the same edge or neither is.
  // The rst term forces both readys low while reset is asserted.
  assign accept         = rst && (state == IDLE) && input_a_tvalid && input_b_tvalid;
  assign input_a_tready = accept;
  assign input_b_tready = accept;

  assign acc_next = add_partial(acc, a_reg, b_reg[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      acc           <= '0;
      count         <= '0;
      output_tdata  <= '0;
      output_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= {{SIZE{1'b0}}, input_a_tdata};
            b_reg <= input_b_tdata;
            acc   <= '0;
            count <= '0;
            state <= MUL;
          end
        end
        // One multiplier bit per cycle. There is no early exit, so latency
        // does not depend on the data.
        MUL: begin
          acc   <= acc_next;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count + 1'b1;
          if (count == LAST_ITER) begin
            output_tdata  <= acc_next;
            output_tvalid <= 1'b1;
            state         <= DONE;
          end
        end
        // Hold the result until the downstream stage takes it. output_tdata
        // keeps its last value after the handshake.
        DONE: begin
          if (output_tready) begin
            output_tvalid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier. The main instance runs at SIZE=8. A second
// instance runs at SIZE=64 for the wide full-scale case. Expected products
// come from plain a*b arithmetic.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;

  logic [7:0]  a_td, b_td;
  logic        a_tv, b_tv, a_tr, b_tr;
  logic [15:0] o_td;
  logic        o_tv, o_tr;

  logic [63:0]  a64_td, b64_td;
  logic         a64_tv, b64_tv, a64_tr, b64_tr;
  logic [127:0] o64_td;
  logic         o64_tv, o64_tr;

  int n_checks;
  int n_pass;

  seq_multiplier #(.SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .input_a_tdata(a_td), .input_a_tvalid(a_tv), .input_a_tready(a_tr),
    .input_b_tdata(b_td), .input_b_tvalid(b_tv), .input_b_tready(b_tr),
    .output_tdata(o_td), .output_tvalid(o_tv), .output_tready(o_tr)
  );

  seq_multiplier #(.SIZE(64)) dut64 (
    .clk(clk), .rst(rst),
    .input_a_tdata(a64_td), .input_a_tvalid(a64_tv), .input_a_tready(a64_tr),
    .input_b_tdata(b64_td), .input_b_tvalid(b64_tv), .input_b_tready(b64_tr),
    .output_tdata(o64_td), .output_tvalid(o64_tv), .output_tready(o64_tr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  function automatic logic [127:0] model64(input logic [63:0] a, input logic [63:0] b);
    return 128'(a) * 128'(b);
  endfunction

  // Present a pair, check the joint ready, and let the accept edge happen.
  // Afterwards the bus data is scrambled.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input string name);
    a_td = a; b_td = b; a_tv = 1'b1; b_tv = 1'b1;
    #1;
    n_checks++;
    if ({a_tr, b_tr} !== 2'b11) $display("FAIL %s_accept_ready: got %b want 11", name, {a_tr, b_tr});
    else n_pass++;
    @(posedge clk); #1;
    a_tv = 1'b0; b_tv = 1'b0;
    a_td = 8'($urandom); b_td = 8'($urandom);
  endtask

  // Count edges to tvalid while toggling the input valids at random. Then
  // check the latency, the product, and that the readys stayed low.
  task automatic wait_result(input logic [15:0] exp, input string name);
    int lat;
    bit rdy_seen;
    lat = 0;
    rdy_seen = 0;
    while (!o_tv && lat < 100) begin
      a_tv = 1'($urandom); b_tv = 1'($urandom);
      a_td = 8'($urandom); b_td = 8'($urandom);
      @(posedge clk); #1;
      lat++;
      if (!o_tv && (a_tr || b_tr)) rdy_seen = 1;
    end
    a_tv = 1'b0; b_tv = 1'b0;
    n_checks++;
    if (lat !== 8) $display("FAIL %s_latency: got %0d want 8", name, lat);
    else n_pass++;
    n_checks++;
    if (o_td !== exp) $display("FAIL %s_product: got %0d want %0d", name, o_td, exp);
    else n_pass++;
    n_checks++;
    if (rdy_seen !== 1'b0) $display("FAIL %s_busy_ready: got 1 want 0", name);
    else n_pass++;
  endtask

  // The handshake edge happens with output_tready high. After it the block is
  // back in IDLE and offers ready to a presented pair.
  task automatic handshake(input logic [15:0] exp, input string name);
    o_tr = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_tv !== 1'b0) $display("FAIL %s_tvalid_drop: got %b want 0", name, o_tv);
    else n_pass++;
    n_checks++;
    if (o_td !== exp) $display("FAIL %s_tdata_kept: got %0d want %0d", name, o_td, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; o_tr = 1'b1; o64_tr = 1'b1;
    a_tv = 1'b1; b_tv = 1'b1; a_td = 8'd3; b_td = 8'd4;
    a64_tv = 1'b0; b64_tv = 1'b0; a64_td = '0; b64_td = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_tv !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", o_tv);
    else n_pass++;
    n_checks++;
    if (o_td !== 16'd0) $display("FAIL reset_tdata: got %0d want 0", o_td);
    else n_pass++;
    n_checks++;
    if ({a_tr, b_tr} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {a_tr, b_tr});
    else n_pass++;
    a_tv = 1'b0; b_tv = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    start_op(8'd3, 8'd5, "basic");
    wait_result(16'd15, "basic");
    handshake(16'd15, "basic");
    a_tv = 1'b1; b_tv = 1'b1; #1;
    n_checks++;
    if ({a_tr, b_tr} !== 2'b11) $display("FAIL basic_idle_again: got %b want 11", {a_tr, b_tr});
    else n_pass++;
    a_tv = 1'b0; b_tv = 1'b0; #1;
  endtask

  task automatic test_extremes();
    start_op(8'd255, 8'd255, "max");
    wait_result(16'hFE01, "max");
    handshake(16'hFE01, "max");
    start_op(8'd0, 8'd200, "zero");
    wait_result(16'd0, "zero");
    handshake(16'd0, "zero");
  endtask

  task automatic test_lone_valid();
    bit seen;
    seen = 0;
    a_td = 8'd9; b_td = 8'd7; a_tv = 1'b1; b_tv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (a_tr || b_tr) seen = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL lone_valid_ready: got 1 want 0");
    else n_pass++;
    start_op(8'd9, 8'd7, "lone");
    wait_result(16'd63, "lone");
    handshake(16'd63, "lone");
  endtask

  task automatic test_backpressure();
    bit moved, rdy;
    logic [7:0] a, b;
    moved = 0; rdy = 0;
    o_tr = 1'b0;
    start_op(8'd9, 8'd7, "bp");
    wait_result(16'd63, "bp");
    for (int i = 0; i < 20; i++) begin
      a_tv = 1'b1; b_tv = 1'b1; a_td = 8'($urandom); b_td = 8'($urandom);
      #1;
      if (a_tr || b_tr) rdy = 1;
      @(posedge clk); #1;
      if (o_tv !== 1'b1 || o_td !== 16'd63) moved = 1;
    end
    a_tv = 1'b0; b_tv = 1'b0;
    n_checks++;
    if (moved !== 1'b0) $display("FAIL bp_hold: got tvalid=%b tdata=%0d want 1/63", o_tv, o_td);
    else n_pass++;
    n_checks++;
    if (rdy !== 1'b0) $display("FAIL bp_ready: got 1 want 0");
    else n_pass++;
    handshake(16'd63, "bp");
    a = 8'($urandom); b = 8'($urandom);
    start_op(a, b, "bp_next");
    wait_result(model8(a, b), "bp_next");
    handshake(model8(a, b), "bp_next");
  endtask

  task automatic test_reset_midop();
    bit seen;
    seen = 0;
    start_op(8'd100, 8'd100, "abort");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_tv !== 1'b0) $display("FAIL abort_tvalid: got %b want 0", o_tv);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (o_tv || o_td == 16'd10000) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_product: got a product want none");
    else n_pass++;
    start_op(8'd12, 8'd11, "after_abort");
    wait_result(16'd132, "after_abort");
    handshake(16'd132, "after_abort");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      o_tr = 1'b0;
      start_op(a, b, "rand");
      wait_result(model8(a, b), "rand");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      handshake(model8(a, b), "rand");
    end
  endtask

  task automatic test_size64();
    logic [63:0] a, b;
    int lat;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin a = '1; b = '1; end
      else begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      a64_td = a; b64_td = b; a64_tv = 1'b1; b64_tv = 1'b1;
      #1;
      n_checks++;
      if ({a64_tr, b64_tr} !== 2'b11) $display("FAIL w64_accept_ready: got %b want 11", {a64_tr, b64_tr});
      else n_pass++;
      @(posedge clk); #1;
      a64_tv = 1'b0; b64_tv = 1'b0; a64_td = '0; b64_td = '0;
      lat = 0;
      while (!o64_tv && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      n_checks++;
      if (lat !== 64) $display("FAIL w64_latency: got %0d want 64", lat);
      else n_pass++;
      n_checks++;
      if (o64_td !== model64(a, b)) $display("FAIL w64_product: got %h want %h", o64_td, model64(a, b));
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (o64_tv !== 1'b0) $display("FAIL w64_tvalid_drop: got %b want 0", o64_tv);
      else n_pass++;
    end
    n_checks++;
    if (model64('1, '1) !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
      $display("FAIL w64_model_const: got %h want fffffffffffffffe0000000000000001", model64('1, '1));
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_lone_valid();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_size64();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
